// File: rtl/trap_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : trap_ctrl_pkg
//  Description : Shared constants and types for the machine-mode trap
//                sequencer: CSR addresses, mstatus field positions,
//                interrupt masks, mcause codes, event encodings, FSM states.
//  Revision    : 1.0 - initial release
// ============================================================================
package trap_ctrl_pkg;

  // Machine-mode CSR addresses
  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MIP     = 12'h344;

  // mstatus field positions
  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  // mip / mie bit positions and the machine-level interrupt mask
  localparam int          IRQ_MSI_BIT = 3;
  localparam int          IRQ_MTI_BIT = 7;
  localparam int          IRQ_MEI_BIT = 11;
  localparam logic [11:0] IRQ_MASK    = 12'h888;

  // mcause codes
  localparam logic [3:0] CODE_MSI      = 4'd3;
  localparam logic [3:0] CODE_MTI      = 4'd7;
  localparam logic [3:0] CODE_MEI      = 4'd11;
  localparam logic [3:0] EXC_BREAKPOINT = 4'd3;
  localparam logic [3:0] EXC_ECALL_M   = 4'd11;

  // evt_kind one-hot encodings
  localparam logic [2:0] EVT_EBREAK = 3'b001;
  localparam logic [2:0] EVT_ECALL  = 3'b010;
  localparam logic [2:0] EVT_MRET   = 3'b100;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_EPC   = 3'd1,
    S_CAUSE = 3'd2,
    S_STAT  = 3'd3,
    S_RSTAT = 3'd4,
    S_REDIR = 3'd5
  } state_e;

endpackage : trap_ctrl_pkg
`default_nettype wire

// File: rtl/trap_ctrl_irq_sel.sv
`default_nettype none
// ============================================================================
//  Module      : trap_ctrl_irq_sel
//  Description : Combinational machine-interrupt pending detector and
//                priority encoder (MEI > MSI > MTI).
//  Ports       : mstatus_mie - global machine interrupt enable
//                mie, mip    - low 12 bits of mie / mip
//                irq_pend    - an enabled interrupt is pending and MIE=1
//                code        - cause code of the winning interrupt
//  Revision    : 1.0 - initial release
// ============================================================================
module trap_ctrl_irq_sel
  import trap_ctrl_pkg::*;
(
  input  logic        mstatus_mie,
  input  logic [11:0] mie,
  input  logic [11:0] mip,
  output logic        irq_pend,
  output logic [3:0]  code
);

  logic [11:0] w_act;

  assign w_act    = mie & mip & IRQ_MASK;
  assign irq_pend = mstatus_mie & (|w_act);

  always_comb begin
    code = 4'd0;
    if (w_act[IRQ_MEI_BIT])      code = CODE_MEI;
    else if (w_act[IRQ_MSI_BIT]) code = CODE_MSI;
    else if (w_act[IRQ_MTI_BIT]) code = CODE_MTI;
  end

endmodule : trap_ctrl_irq_sel
`default_nettype wire

// File: rtl/trap_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : trap_ctrl
//  Description : Multi-cycle machine-mode trap sequencer. Performs trap-entry
//                (mepc, mcause, mstatus) or mret (mstatus) CSR updates over a
//                single shared write port, then issues one PC redirect.
//                Instruction CSR writes share the port when idle.
//  Ports       : clk, rst                      - clock, sync active-high reset
//                evt_valid/kind/ready          - ebreak/ecall/mret handshake
//                pc, mstatus, mie, mip, mtvec, mepc - current core/CSR state
//                inst_csr_wen/addr/wdata/ready - instruction CSR write request
//                csr_wen/waddr/wdata           - CSR file write port
//                busy                          - sequence in progress
//                redirect_valid/pc             - one-cycle PC redirect
//                irq_taken                     - interrupt accepted strobe
//  Revision    : 1.0 - initial release
// ============================================================================
module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            evt_valid,
  input  logic [2:0]      evt_kind,
  output logic            evt_ready,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] mstatus,
  input  logic [XLEN-1:0] mie,
  input  logic [XLEN-1:0] mip,
  input  logic [XLEN-1:0] mtvec,
  input  logic [XLEN-1:0] mepc,
  input  logic            inst_csr_wen,
  input  logic [11:0]     inst_csr_addr,
  input  logic [XLEN-1:0] inst_csr_wdata,
  output logic            inst_csr_ready,
  output logic            csr_wen,
  output logic [11:0]     csr_waddr,
  output logic [XLEN-1:0] csr_wdata,
  output logic            busy,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            irq_taken
);

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] cause_q, cause_d;
  logic            mret_q, mret_d;

  logic            irq_pend;
  logic [3:0]      irq_code;
  logic [XLEN-1:0] w_base;
  logic [XLEN-1:0] w_stat_entry;
  logic [XLEN-1:0] w_stat_return;
  logic            w_unused;

  // Only the machine-level interrupt bits participate.
  assign w_unused = ^{mie[XLEN-1:12], mip[XLEN-1:12]};

  trap_ctrl_irq_sel u_irq_sel (
    .mstatus_mie (mstatus[MSTATUS_MIE]),
    .mie         (mie[11:0]),
    .mip         (mip[11:0]),
    .irq_pend    (irq_pend),
    .code        (irq_code)
  );

  assign w_base = {mtvec[XLEN-1:2], 2'b00};

  // Trap entry: stash MIE in MPIE, disable interrupts, record M-mode as MPP.
  always_comb begin
    w_stat_entry                                 = mstatus;
    w_stat_entry[MSTATUS_MPIE]                   = mstatus[MSTATUS_MIE];
    w_stat_entry[MSTATUS_MIE]                    = 1'b0;
    w_stat_entry[MSTATUS_MPP_HI:MSTATUS_MPP_LO]  = 2'b11;
  end

  // Trap return: restore MIE from MPIE and re-arm MPIE.
  always_comb begin
    w_stat_return                                = mstatus;
    w_stat_return[MSTATUS_MIE]                   = mstatus[MSTATUS_MPIE];
    w_stat_return[MSTATUS_MPIE]                  = 1'b1;
    w_stat_return[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      cause_q <= '0;
      mret_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cause_q <= cause_d;
      mret_q  <= mret_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    cause_d        = cause_q;
    mret_d         = mret_q;
    evt_ready      = 1'b0;
    inst_csr_ready = 1'b0;
    csr_wen        = 1'b0;
    csr_waddr      = '0;
    csr_wdata      = '0;
    busy           = (state_q != S_IDLE);
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    irq_taken      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // Acceptance is suppressed during reset so no strobe escapes;
        // instruction writes still forward.
        if (irq_pend && !rst) begin
          irq_taken = 1'b1;
          pc_d      = pc;
          cause_d   = {1'b1, {(XLEN-5){1'b0}}, irq_code};
          mret_d    = 1'b0;
          state_d   = S_EPC;
        end else if (evt_valid && !rst &&
                     (evt_kind == EVT_EBREAK || evt_kind == EVT_ECALL)) begin
          evt_ready = 1'b1;
          pc_d      = pc;
          cause_d   = {{(XLEN-4){1'b0}},
                       (evt_kind == EVT_ECALL) ? EXC_ECALL_M : EXC_BREAKPOINT};
          mret_d    = 1'b0;
          state_d   = S_EPC;
        end else if (evt_valid && !rst && evt_kind == EVT_MRET) begin
          evt_ready = 1'b1;
          mret_d    = 1'b1;
          state_d   = S_RSTAT;
        end else begin
          csr_wen        = inst_csr_wen;
          csr_waddr      = inst_csr_addr;
          csr_wdata      = inst_csr_wdata;
          inst_csr_ready = inst_csr_wen;
        end
      end
      S_EPC: begin
        csr_wen   = 1'b1;
        csr_waddr = CSR_MEPC;
        csr_wdata = {pc_q[XLEN-1:2], 2'b00};
        state_d   = S_CAUSE;
      end
      S_CAUSE: begin
        csr_wen   = 1'b1;
        csr_waddr = CSR_MCAUSE;
        csr_wdata = cause_q;
        state_d   = S_STAT;
      end
      S_STAT: begin
        csr_wen   = 1'b1;
        csr_waddr = CSR_MSTATUS;
        csr_wdata = w_stat_entry;
        state_d   = S_REDIR;
      end
      S_RSTAT: begin
        csr_wen   = 1'b1;
        csr_waddr = CSR_MSTATUS;
        csr_wdata = w_stat_return;
        state_d   = S_REDIR;
      end
      S_REDIR: begin
        redirect_valid = 1'b1;
        if (mret_q) begin
          redirect_pc = {mepc[XLEN-1:2], 2'b00};
        end else if (mtvec[1:0] == 2'b01 && cause_q[XLEN-1]) begin
          // Vectored mode: interrupts land at base + 4*code.
          redirect_pc = w_base + {{(XLEN-6){1'b0}}, cause_q[3:0], 2'b00};
        end else begin
          redirect_pc = w_base;
        end
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule : trap_ctrl
`default_nettype wire
